// File: rtl/hmc960_pkg.sv
// Shared definitions for the HMC960 configuration sequencer: frame field
// positions, table entry layout, FSM state encodings and the frame builder.
package hmc960_pkg;

    localparam logic [2:0] CHIP_ADDR_DEF = 3'b110;

    // Frame field positions (frame is shifted out MSB first by the engine)
    localparam int DATA_MSB = 31;
    localparam int ADDR_LSB = 3;
    localparam int CHIP_LSB = 0;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 24;
    localparam int DATA_LSB = ADDR_LSB + ADDR_W;

    // Table entry layout: {reg_addr[4:0], reg_data[23:0]}
    localparam int ENTRY_W  = ADDR_W + DATA_W;

    // Sequencer states (plain constants so older flows can reuse the encoding)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_WAIT_END = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_FINISH   = 3'd5;
    localparam logic [2:0] ST_ERR      = 3'd6;

    // Build the 32-bit HMC960 frame {reg_data, reg_addr, chip_addr}
    function automatic logic [31:0] build_frame(input logic [ENTRY_W-1:0] entry,
                                                input logic [2:0]         chip);
        logic [31:0] frame;
        frame = 32'h0000_0000;
        frame[DATA_MSB:DATA_LSB]     = entry[DATA_W-1:0];
        frame[DATA_LSB-1:ADDR_LSB]   = entry[ENTRY_W-1:DATA_W];
        frame[CHIP_LSB+2:CHIP_LSB]   = chip;
        return frame;
    endfunction

endpackage

// File: rtl/hmc960_cfg_seq_if.sv
// Link between the configuration sequencer and the HMC960 serial engine.
// The sequencer is the master: it owns the frame and the transfer request,
// the engine reports transfer progress on its chip-select line.
interface hmc960_spi_if;

    logic [31:0] spi_tx_data;
    logic        spi_xfer_begin;
    logic        spi_cs;

    modport master (
        output spi_tx_data,
        output spi_xfer_begin,
        input  spi_cs
    );

    modport slave (
        input  spi_tx_data,
        input  spi_xfer_begin,
        output spi_cs
    );

endinterface

// File: rtl/hmc960_cfg_tbl.sv
// Register-write table for the HMC960 sequencer: DEPTH entries of
// {reg_addr, reg_data}, one synchronous write port, one combinational read port.
// Contents deliberately survive reset so a host can reload only what changed.
module hmc960_cfg_tbl
    import hmc960_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Host write port; no reset so the table is retained across resets
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hmc960_cfg_seq.sv
// HMC960 configuration sequencer. On a rising edge of start it walks the
// register table from index 0, hands each entry to the serial engine as a
// 32-bit frame and follows the engine's chip-select to see each transfer
// accepted and completed, keeping a minimum idle gap between frames.
module hmc960_cfg_seq
    import hmc960_pkg::*;
#(
    parameter  int         DEPTH      = 16,
    parameter  logic [2:0] CHIP_ADDR  = CHIP_ADDR_DEF,
    parameter  int         GAP_CYCLES = 8,
    parameter  int         TIMEOUT    = 4096,
    localparam int         AW         = $clog2(DEPTH),
    localparam int         CW         = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CW-1:0]      num_words,
    input  logic               tbl_we,
    input  logic [AW-1:0]      tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_wdata,
    hmc960_spi_if.master       spi,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CW-1:0]      words_sent
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] ZERO_C   = CW'(0);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [2:0]         r_state;
    logic               r_start_q;
    logic               r_cs_meta;
    logic               r_cs_sync;
    logic [CW-1:0]      r_n;
    logic [CW-1:0]      r_idx;
    logic [15:0]        r_cnt;
    logic [31:0]        r_tx_data;
    logic               r_xfer;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [CW-1:0]      r_words;

    logic               w_start_edge;
    logic [CW-1:0]      w_n_clamped;
    logic               w_tbl_we;
    logic [ENTRY_W-1:0] w_rd_entry;

    // Table is frozen for the whole sequence; only an idle sequencer accepts writes
    assign w_tbl_we     = tbl_we & (r_state == ST_IDLE);
    assign w_start_edge = start & ~r_start_q;
    assign w_n_clamped  = (num_words > DEPTH_C) ? DEPTH_C : num_words;

    hmc960_cfg_tbl #(
        .DEPTH (DEPTH)
    ) u_tbl (
        .clk     (clk),
        .i_we    (w_tbl_we),
        .i_waddr (tbl_addr),
        .i_wdata (tbl_wdata),
        .i_raddr (r_idx[AW-1:0]),
        .o_rdata (w_rd_entry)
    );

    // Delayed copy of start for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= start;
        end
    end

    // Two-flop synchronizer for the engine chip-select (idle level is high)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
        end else begin
            r_cs_meta <= spi.spi_cs;
            r_cs_sync <= r_cs_meta;
        end
    end

    // Sequencer FSM with shared wait/gap counter and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_n       <= ZERO_C;
            r_idx     <= ZERO_C;
            r_cnt     <= 16'h0000;
            r_tx_data <= 32'h0000_0000;
            r_xfer    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_words   <= ZERO_C;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_n     <= w_n_clamped;
                        r_idx   <= ZERO_C;
                        r_words <= ZERO_C;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= 16'h0000;
                        r_state <= (w_n_clamped == ZERO_C) ? ST_FINISH : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Request stays low this cycle so the engine sees a clean rising edge
                    r_tx_data <= build_frame(w_rd_entry, CHIP_ADDR);
                    r_xfer    <= 1'b1;
                    r_cnt     <= 16'h0000;
                    r_state   <= ST_REQ;
                end
                ST_REQ: begin
                    if (!r_cs_sync) begin
                        r_cnt   <= 16'h0000;
                        r_state <= ST_WAIT_END;
                    end else if (r_cnt == TMO_LAST) begin
                        r_xfer  <= 1'b0;
                        r_cnt   <= 16'h0000;
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
                end
                ST_WAIT_END: begin
                    // Request is held high: the engine only reacts to its edges
                    if (r_cs_sync) begin
                        r_xfer  <= 1'b0;
                        r_words <= r_words + ONE_C;
                        r_idx   <= r_idx + ONE_C;
                        r_cnt   <= 16'h0000;
                        r_state <= ST_GAP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_xfer  <= 1'b0;
                        r_cnt   <= 16'h0000;
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 16'h0000;
                        r_state <= (r_idx < r_n) ? ST_LOAD : ST_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'h0000;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_xfer  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_error <= 1'b1;
                    r_cnt   <= 16'h0000;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_xfer  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'h0000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi.spi_tx_data    = r_tx_data;
    assign spi.spi_xfer_begin = r_xfer;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;
    assign words_sent         = r_words;

endmodule
